// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Registered pipeline stage boundary with a two-entry skid buffer. Carries
//   {ctrl, idx, data} from an upstream valid/ready producer to a downstream
//   valid/ready consumer. Back-pressure is absorbed by the SKID slot, so
//   in_ready is a plain flop with no combinational path from out_ready.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous kill of every held entry
//   in_valid/in_ready upstream handshake (in_ready registered)
//   in_ctrl/idx/data  incoming entry payload
//   out_valid/ready   downstream handshake
//   out_ctrl/idx/data presented entry payload (MAIN slot)
//   occupancy         number of held entries, 0..2
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 7,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    localparam int ENT_W = CTRL_W + IDX_W + DATA_W;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             ready_q;
    logic [ENT_W-1:0] main_q, skid_q, in_ent;
    logic             accept, drain;
    logic             main_ld_in, main_ld_skid, skid_ld;

    assign in_ent = {in_ctrl, in_idx, in_data};
    assign accept = in_valid & ready_q;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_nxt    = state;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    main_ld_in = 1'b1;
                    state_nxt  = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_ld_in = 1'b1;
                end else if (accept) begin
                    skid_ld   = 1'b1;
                    state_nxt = FULL;
                end else if (drain) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    main_ld_skid = 1'b1;
                    state_nxt    = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush wins: the offered entry is dropped and MAIN keeps its old
        // payload, so a killed entry never shows up on out_*.
        if (flush) begin
            state_nxt    = EMPTY;
            main_ld_in   = 1'b0;
            main_ld_skid = 1'b0;
            skid_ld      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state   <= state_nxt;
            // Ready is computed from the next state so it is a clean flop.
            ready_q <= (state_nxt != FULL);
            if (main_ld_in)        main_q <= in_ent;
            else if (main_ld_skid) main_q <= skid_q;
            if (skid_ld)           skid_q <= in_ent;
        end
    end

    assign in_ready                      = ready_q;
    assign out_valid                     = (state != EMPTY);
    assign occupancy                     = 2'(state);
    assign {out_ctrl, out_idx, out_data} = main_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
    localparam int DATA_W = 64;
    localparam int CTRL_W = 12;
    localparam int IDX_W  = 5;
    localparam int ENT_W  = CTRL_W + IDX_W + DATA_W;
    typedef logic [ENT_W-1:0] entry_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [IDX_W-1:0]  in_idx;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [IDX_W-1:0]  out_idx;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    int checks   = 0;
    int failures = 0;
    entry_t q[$];

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_idx(in_idx), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_idx(out_idx), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic entry_t mk(input logic [CTRL_W-1:0] c, input logic [IDX_W-1:0] i,
                                  input logic [DATA_W-1:0] d);
        return {c, i, d};
    endfunction

    // Called at a negedge: drives inputs, samples registered outputs, keeps
    // the scoreboard, then advances to the next negedge. No comparisons here.
    task automatic step(input bit v, input entry_t e, input bit r, input bit f,
                        output bit acc, output bit drn, output bit under,
                        output entry_t exp, output entry_t obs);
        in_valid = v;
        {in_ctrl, in_idx, in_data} = e;
        out_ready = r;
        flush = f;
        obs = {out_ctrl, out_idx, out_data};
        acc = v && in_ready;
        drn = out_valid && r;
        under = 1'b0;
        exp = '0;
        if (drn) begin
            if (q.size() == 0) under = 1'b1;
            else exp = q.pop_front();
        end
        if (acc && !f) q.push_back(e);
        @(posedge clk);
        if (f) q.delete();
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        bit a, d, u;
        entry_t ex, ob;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = i[0];
            in_data   = {$urandom, $urandom};
            in_idx    = IDX_W'($urandom);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_ctrl !== '0 || out_idx !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b data=%h ctrl=%h idx=%h, want all 0",
                     out_valid, out_data, out_ctrl, out_idx);
        end
        checks++;
        if (occupancy !== 2'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_occ_ready: got occ=%0d ready=%b, want occ=0 ready=1", occupancy, in_ready);
        end
        rst_n = 1'b1;
        step(1, mk('0, 5'd3, 64'hA5A5A5A5), 0, 0, a, d, u, ex, ob);
        checks++;
        if (!a || out_valid !== 1'b1 || out_data !== 64'hA5A5A5A5 || out_idx !== 5'd3) begin
            failures++;
            $display("FAIL reset_first_accept: got acc=%b valid=%b data=%h idx=%0d, want 1 1 a5a5a5a5 3",
                     a, out_valid, out_data, out_idx);
        end
        step(0, '0, 1, 0, a, d, u, ex, ob);
        checks++;
        if (!d || u || ob !== ex || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL reset_drain: got drn=%b under=%b obs=%h occ=%0d, want drn exp=%h occ=0",
                     d, u, ob, occupancy, ex);
        end
    endtask

    task automatic test_streaming();
        bit a, d, u;
        entry_t ex, ob;
        int ndrain = 0, bad_ready = 0, bad_occ = 0, bad_data = 0;
        for (int c = 0; c < 10; c++) begin
            if (in_ready !== 1'b1) bad_ready++;
            if (c >= 1 && c <= 8 && (occupancy !== 2'd1 || out_valid !== 1'b1)) bad_occ++;
            step(c < 8, mk(12'(c), 5'(c), 64'(c + 1)), 1, 0, a, d, u, ex, ob);
            if (d) begin
                ndrain++;
                if (u || ob !== ex || ob[DATA_W-1:0] !== 64'(c)) bad_data++;
            end
        end
        checks++;
        if (bad_ready != 0) begin
            failures++;
            $display("FAIL stream_ready: in_ready low in %0d cycles, want 0", bad_ready);
        end
        checks++;
        if (bad_occ != 0) begin
            failures++;
            $display("FAIL stream_occ: occupancy!=1 in %0d cycles, want 0", bad_occ);
        end
        checks++;
        if (ndrain != 8 || bad_data != 0) begin
            failures++;
            $display("FAIL stream_data: got %0d outputs with %0d bad, want 8 with 0 bad", ndrain, bad_data);
        end
    endtask

    task automatic test_backpressure();
        bit a, d, u;
        entry_t ex, ob;
        logic [DATA_W-1:0] vals[3] = '{64'h10, 64'h20, 64'h30};
        int p = 0, ndrain = 0, bad = 0;
        for (int c = 0; c < 9; c++) begin
            if (c == 2) begin
                checks++;
                if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
                    failures++;
                    $display("FAIL bp_full: got ready=%b occ=%0d, want ready=0 occ=2", in_ready, occupancy);
                end
            end
            if (c == 5) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_ready_return: got ready=%b, want 1", in_ready);
                end
            end
            step(p < 3, mk('0, '0, vals[p % 3]), c >= 4, 0, a, d, u, ex, ob);
            if (a) p++;
            if (c == 3) begin
                checks++;
                if (p != 2) begin
                    failures++;
                    $display("FAIL bp_held: got %0d accepted under stall, want 2", p);
                end
            end
            if (d) begin
                if (u || ob !== ex || ob[DATA_W-1:0] !== vals[ndrain % 3]) bad++;
                ndrain++;
            end
        end
        checks++;
        if (ndrain != 3 || bad != 0 || q.size() != 0) begin
            failures++;
            $display("FAIL bp_order: got %0d outputs, %0d bad, %0d left, want 3 0 0", ndrain, bad, q.size());
        end
    endtask

    task automatic test_flush();
        bit a, d, u;
        entry_t ex, ob;
        step(1, mk('0, '0, 64'h1), 0, 0, a, d, u, ex, ob);
        step(1, mk('0, '0, 64'h2), 0, 0, a, d, u, ex, ob);
        step(1, mk('0, '0, 64'h55), 0, 1, a, d, u, ex, ob);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_data === 64'h55) begin
            failures++;
            $display("FAIL flush_full: got valid=%b occ=%0d ready=%b data=%h, want 0 0 1 not 55",
                     out_valid, occupancy, in_ready, out_data);
        end
        // Flush in ONE with a same-cycle accept: the offered entry must be lost.
        step(1, mk('0, '0, 64'h3), 0, 0, a, d, u, ex, ob);
        step(1, mk('0, '0, 64'h66), 0, 1, a, d, u, ex, ob);
        step(0, '0, 1, 0, a, d, u, ex, ob);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || d || out_data === 64'h66) begin
            failures++;
            $display("FAIL flush_one: got valid=%b occ=%0d drn=%b data=%h, want 0 0 0 not 66",
                     out_valid, occupancy, d, out_data);
        end
    endtask

    task automatic test_async_reset();
        bit a, d, u;
        entry_t ex, ob;
        step(1, mk(12'h7, 5'h1, 64'hDEAD), 0, 0, a, d, u, ex, ob);
        step(1, mk(12'h8, 5'h2, 64'hBEEF), 0, 0, a, d, u, ex, ob);
        checks++;
        if (occupancy !== 2'd2) begin
            failures++;
            $display("FAIL arst_setup: got occ=%0d, want 2", occupancy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 ||
            out_data !== '0 || out_ctrl !== '0 || out_idx !== '0) begin
            failures++;
            $display("FAIL arst_midstream: got valid=%b occ=%0d ready=%b data=%h, want 0 0 1 0",
                     out_valid, occupancy, in_ready, out_data);
        end
        #1 rst_n = 1'b1;
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit a, d, u;
        entry_t ex, ob;
        bit stalled;
        int bad_order = 0, bad_stable = 0, nout = 0;
        for (int c = 0; c < 600; c++) begin
            entry_t e = mk(12'($urandom), 5'($urandom), {$urandom, $urandom});
            bit r = ($urandom_range(0, 2) != 0) || c >= 580;
            stalled = out_valid && !r;
            step(($urandom_range(0, 2) != 0) && c < 580, e, r, 0, a, d, u, ex, ob);
            if (d) begin
                nout++;
                if (u || ob !== ex) bad_order++;
            end
            if (stalled && (out_valid !== 1'b1 || {out_ctrl, out_idx, out_data} !== ob)) bad_stable++;
        end
        checks++;
        if (bad_order != 0 || nout == 0) begin
            failures++;
            $display("FAIL rand_order: %0d bad of %0d outputs, want 0 bad", bad_order, nout);
        end
        checks++;
        if (bad_stable != 0) begin
            failures++;
            $display("FAIL rand_stable: %0d unstable stall cycles, want 0", bad_stable);
        end
        checks++;
        if (q.size() != 0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL rand_lossless: %0d entries undelivered, occ=%0d, want 0 0", q.size(), occupancy);
        end
    endtask

    initial begin
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_idx = '0; in_data = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
